// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing, derived totals,
// sync-window bounds and the registered control-bit bundle. The colour
// controller imports the same constants so both blocks agree on the raster.
package vga_timing_gen_pkg;

    // Default horizontal timing, in pixels
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // Default vertical timing, in lines
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Derived totals
    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync windows, inclusive on both ends
    localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC - 1;
    localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC - 1;

    // Default counter width; must hold both H_TOTAL-1 and V_TOTAL-1
    localparam int unsigned VGA_CW = 10;

    // Registered single-bit timing outputs, kept together so they share one
    // reset value and one register stage with the counters
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic line_start;
        logic frame_start;
    } vga_ctrl_t;

    // Drive a sync line: the active level is the polarity, idle is its inverse
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator and its consumers.
// The generator (master) takes the pixel-enable strobe and drives the
// counters and control strobes; consumers (slave) only observe.
interface vga_timing_gen_if #(
    parameter int unsigned CW = vga_timing_gen_pkg::VGA_CW
);
    logic          pix_en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_en,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output video_on,
        output line_start,
        output frame_start
    );

    modport slave (
        input pix_en,
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input video_on,
        input line_start,
        input frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Mod-N axis counter with enable. Clearing parks it at N-1 so the first
// enabled cycle afterwards lands on 0. Exposes both the registered value and
// the value it will take on the next edge, so downstream decode can be
// registered alongside the count with no skew.
module vga_axis_counter #(
    parameter int unsigned N  = 800,
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Terminal count: the next enabled cycle rolls back to zero
    assign wrap = (count_q == LAST);

    // Next count: hold when disabled, roll over at N-1, otherwise step by one
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (wrap) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register, cleared asynchronously to the terminal value
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Two cascaded axis counters produce the pixel
// column and line; sync, active-video and start strobes are decoded from the
// counters' next values and registered in the same edge as the counters, so
// every output changes together with hcount/vcount.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = VGA_CW
) (
    input  logic             dclk,
    input  logic             clr,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode bounds at counter width; all comparisons are unsigned CW-bit
    localparam logic [CW-1:0] H_ACT_LIM = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LIM = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reset image of the control bits: syncs idle, no video, no strobes
    localparam vga_ctrl_t CTRL_RST = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        video_on:    1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    // A counter too narrow for its total would silently alias positions
    if ((CW < $clog2(H_TOTAL)) || (CW < $clog2(V_TOTAL))) begin : g_cw_too_small
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CW-1:0] hcount_cur;
    logic [CW-1:0] hcount_nxt;
    logic          h_wrap;
    logic [CW-1:0] vcount_cur;
    logic [CW-1:0] vcount_nxt;
    logic          v_wrap;
    logic          v_en;

    vga_ctrl_t ctrl_q;
    vga_ctrl_t ctrl_d;

    // Column counter advances on every pixel strobe
    vga_axis_counter #(
        .N  (H_TOTAL),
        .CW (CW)
    ) u_h_cnt (
        .clk       (dclk),
        .clr       (clr),
        .en        (bus.pix_en),
        .count     (hcount_cur),
        .count_nxt (hcount_nxt),
        .wrap      (h_wrap)
    );

    // Line counter advances only when the column counter rolls over
    assign v_en = bus.pix_en & h_wrap;

    vga_axis_counter #(
        .N  (V_TOTAL),
        .CW (CW)
    ) u_v_cnt (
        .clk       (dclk),
        .clr       (clr),
        .en        (v_en),
        .count     (vcount_cur),
        .count_nxt (vcount_nxt),
        .wrap      (v_wrap)
    );

    // Decode the control bits from the position the counters move to next;
    // strobes fire only on the advancing edge, so a held pix_en=0 drops them
    always_comb begin
        ctrl_d             = CTRL_RST;
        ctrl_d.hsync       = sync_level((hcount_nxt >= HS_START) && (hcount_nxt <= HS_END),
                                        HSYNC_POL);
        ctrl_d.vsync       = sync_level((vcount_nxt >= VS_START) && (vcount_nxt <= VS_END),
                                        VSYNC_POL);
        ctrl_d.video_on    = (hcount_nxt < H_ACT_LIM) && (vcount_nxt < V_ACT_LIM);
        ctrl_d.line_start  = bus.pix_en & h_wrap;
        ctrl_d.frame_start = bus.pix_en & h_wrap & v_wrap;
    end

    // Control register, forced to the idle image asynchronously on clear
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            ctrl_q <= CTRL_RST;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.hcount      = hcount_cur;
    assign bus.vcount      = vcount_cur;
    assign bus.hsync       = ctrl_q.hsync;
    assign bus.vsync       = ctrl_q.vsync;
    assign bus.video_on    = ctrl_q.video_on;
    assign bus.line_start  = ctrl_q.line_start;
    assign bus.frame_start = ctrl_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny,
// positive-polarity instance whose short frame makes frame-level wraps
// reachable. Reference model tracks a linear pixel index per frame.
module tb_vga_timing_gen;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hpol; bit vpol;
    } cfg_t;

    typedef struct {
        bit pe;
        int h;
        int v;
        bit hs;
        bit vo;
        bit ls;
        bit fs;
    } vec_t;

    logic dclk;
    logic clr;

    vga_timing_gen_if #(.CW(10)) bus_a ();
    vga_timing_gen_if #(.CW(4))  bus_b ();

    vga_timing_gen #(.CW(10)) dut_a (
        .dclk (dclk),
        .clr  (clr),
        .bus  (bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
    ) dut_b (
        .dclk (dclk),
        .clr  (clr),
        .bus  (bus_b)
    );

    int   checks = 0;
    int   errors = 0;
    cfg_t cfg_a;
    cfg_t cfg_b;
    int   pos_a, pos_b;
    bit   ls_a, fs_a, ls_b, fs_b;

    initial begin
        dclk = 1'b0;
        forever #5 dclk = ~dclk;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int line_len(cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int frame_len(cfg_t c);
        return line_len(c) * (c.va + c.vf + c.vs + c.vb);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge of the model: position is a linear index into the frame
    task automatic model_adv(input cfg_t c, input bit pe, inout int pos,
                             output bit ls, output bit fs);
        if (clr) begin
            pos = frame_len(c) - 1;
            ls  = 1'b0;
            fs  = 1'b0;
        end else if (pe) begin
            pos = (pos + 1) % frame_len(c);
            ls  = (pos % line_len(c)) == 0;
            fs  = (pos == 0);
        end else begin
            ls = 1'b0;
            fs = 1'b0;
        end
    endtask

    task automatic check_dut(input string nm, input cfg_t c, input int pos,
                             input bit ls, input bit fs,
                             input logic [31:0] h, input logic [31:0] v,
                             input logic hs, input logic vs, input logic vo,
                             input logic lsd, input logic fsd);
        int eh, ev;
        bit hact, vact, evo;
        eh   = pos % line_len(c);
        ev   = pos / line_len(c);
        hact = (eh >= c.ha + c.hf) && (eh < c.ha + c.hf + c.hs);
        vact = (ev >= c.va + c.vf) && (ev < c.va + c.vf + c.vs);
        evo  = (eh < c.ha) && (ev < c.va);
        cmp({nm, ".hcount"}, h, eh);
        cmp({nm, ".vcount"}, v, ev);
        cmp({nm, ".hsync"}, 32'(hs), 32'(hact ? c.hpol : !c.hpol));
        cmp({nm, ".vsync"}, 32'(vs), 32'(vact ? c.vpol : !c.vpol));
        cmp({nm, ".video_on"}, 32'(vo), 32'(evo));
        cmp({nm, ".line_start"}, 32'(lsd), 32'(ls));
        cmp({nm, ".frame_start"}, 32'(fsd), 32'(fs));
    endtask

    task automatic check_all();
        check_dut("A", cfg_a, pos_a, ls_a, fs_a, 32'(bus_a.hcount), 32'(bus_a.vcount),
                  bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.line_start, bus_a.frame_start);
        check_dut("B", cfg_b, pos_b, ls_b, fs_b, 32'(bus_b.hcount), 32'(bus_b.vcount),
                  bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.line_start, bus_b.frame_start);
    endtask

    // Drive pix_en, take one edge, advance the model, sample 1 unit later
    task automatic step(input bit pe);
        bus_a.pix_en = pe;
        bus_b.pix_en = pe;
        @(posedge dclk);
        model_adv(cfg_a, pe, pos_a, ls_a, fs_a);
        model_adv(cfg_b, pe, pos_b, ls_b, fs_b);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        pos_a = frame_len(cfg_a) - 1;
        pos_b = frame_len(cfg_b) - 1;
        ls_a = 1'b0; fs_a = 1'b0;
        ls_b = 1'b0; fs_b = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        int   hs_cnt, vo_cnt, vs_cnt, fs_cnt, ls_extra;
        int   first_hs, first_vo_off;

        cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg_b = '{8, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b1};

        //          pe  h    v    hs  vo  ls  fs
        vecs[0] = '{0, 799, 524, 1,  0,  0,  0};
        vecs[1] = '{1, 0,   0,   1,  1,  1,  1};
        vecs[2] = '{1, 1,   0,   1,  1,  0,  0};
        vecs[3] = '{0, 1,   0,   1,  1,  0,  0};
        vecs[4] = '{1, 2,   0,   1,  1,  0,  0};
        vecs[5] = '{0, 2,   0,   1,  1,  0,  0};

        // Reset takes effect on assertion, ahead of any clock edge
        clr = 1'b0;
        bus_a.pix_en = 1'b1;
        bus_b.pix_en = 1'b1;
        model_reset();
        #1 clr = 1'b1;
        #1 check_all();
        repeat (3) step(1'b1);
        clr = 1'b0;

        // Table-driven start-up sequence on the full-size instance
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].pe);
            cmp($sformatf("vec%0d.hcount", i), 32'(bus_a.hcount), vecs[i].h);
            cmp($sformatf("vec%0d.vcount", i), 32'(bus_a.vcount), vecs[i].v);
            cmp($sformatf("vec%0d.hsync", i), 32'(bus_a.hsync), 32'(vecs[i].hs));
            cmp($sformatf("vec%0d.video_on", i), 32'(bus_a.video_on), 32'(vecs[i].vo));
            cmp($sformatf("vec%0d.line_start", i), 32'(bus_a.line_start), 32'(vecs[i].ls));
            cmp($sformatf("vec%0d.frame_start", i), 32'(bus_a.frame_start), 32'(vecs[i].fs));
        end

        // One full line at full rate: sync window, active width, line period
        n = 0;
        while (bus_a.line_start !== 1'b1 && n < 1000) begin
            step(1'b1);
            n++;
        end
        cmp("A.line_start_found", 32'(n < 1000), 32'd1);
        hs_cnt = 0; vo_cnt = 0; ls_extra = 0;
        first_hs = -1; first_vo_off = -1;
        for (int k = 0; k < 800; k++) begin
            if (bus_a.hsync === 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(bus_a.hcount);
            end
            if (bus_a.video_on === 1'b1) vo_cnt++;
            else if (first_vo_off < 0) first_vo_off = int'(bus_a.hcount);
            if (k > 0 && bus_a.line_start === 1'b1) ls_extra++;
            step(1'b1);
        end
        cmp("A.hsync_width", hs_cnt, 96);
        cmp("A.hsync_first_col", first_hs, 656);
        cmp("A.video_on_width", vo_cnt, 640);
        cmp("A.video_off_col", first_vo_off, 640);
        cmp("A.line_start_extra", ls_extra, 0);
        cmp("A.line_period", 32'(bus_a.line_start), 32'd1);

        // Half-rate pixel strobe
        for (int k = 0; k < 3000; k++) step(k % 2 == 0);

        // One full frame of the small instance at full rate
        n = 0;
        while (bus_b.frame_start !== 1'b1 && n < 400) begin
            step(1'b1);
            n++;
        end
        cmp("B.frame_start_found", 32'(n < 400), 32'd1);
        vo_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 135; k++) begin
            if (bus_b.video_on === 1'b1) vo_cnt++;
            if (bus_b.vsync === 1'b1) vs_cnt++;
            if (k > 0 && bus_b.frame_start === 1'b1) fs_cnt++;
            step(1'b1);
        end
        cmp("B.video_on_per_frame", vo_cnt, 40);
        cmp("B.vsync_cycles", vs_cnt, 30);
        cmp("B.frame_start_extra", fs_cnt, 0);
        cmp("B.frame_period", 32'(bus_b.frame_start), 32'd1);

        // Line wrap mid-frame: (14,3) -> (0,4), line but not frame start
        n = 0;
        while (!(bus_b.hcount == 4'd14 && bus_b.vcount == 4'd3) && n < 400) begin
            step(1'b1);
            n++;
        end
        cmp("B.reach_14_3", 32'(n < 400), 32'd1);
        step(1'b1);
        cmp("B.wrap_line.hcount", 32'(bus_b.hcount), 32'd0);
        cmp("B.wrap_line.vcount", 32'(bus_b.vcount), 32'd4);
        cmp("B.wrap_line.line_start", 32'(bus_b.line_start), 32'd1);
        cmp("B.wrap_line.frame_start", 32'(bus_b.frame_start), 32'd0);

        // Frame wrap: (14,8) -> (0,0) with frame_start
        n = 0;
        while (!(bus_b.hcount == 4'd14 && bus_b.vcount == 4'd8) && n < 400) begin
            step(1'b1);
            n++;
        end
        cmp("B.reach_14_8", 32'(n < 400), 32'd1);
        step(1'b1);
        cmp("B.wrap_frame.hcount", 32'(bus_b.hcount), 32'd0);
        cmp("B.wrap_frame.vcount", 32'(bus_b.vcount), 32'd0);
        cmp("B.wrap_frame.frame_start", 32'(bus_b.frame_start), 32'd1);

        // Random pixel strobe, roughly two-thirds duty
        for (int k = 0; k < 3000; k++) step($urandom_range(0, 2) != 0);

        // Asynchronous clear in the middle of a line
        n = 0;
        while (bus_a.hcount != 10'd300 && n < 1000) begin
            step(1'b1);
            n++;
        end
        cmp("A.reach_col_300", 32'(n < 1000), 32'd1);
        #1 clr = 1'b1;
        model_reset();
        #1;
        cmp("A.async.hcount", 32'(bus_a.hcount), 32'd799);
        cmp("A.async.vcount", 32'(bus_a.vcount), 32'd524);
        cmp("A.async.hsync", 32'(bus_a.hsync), 32'd1);
        cmp("A.async.vsync", 32'(bus_a.vsync), 32'd1);
        cmp("A.async.video_on", 32'(bus_a.video_on), 32'd0);
        check_all();
        step(1'b1);
        step(1'b1);
        clr = 1'b0;
        step(1'b0);
        step(1'b1);
        cmp("A.restart.hcount", 32'(bus_a.hcount), 32'd0);
        cmp("A.restart.vcount", 32'(bus_a.vcount), 32'd0);
        cmp("A.restart.frame_start", 32'(bus_a.frame_start), 32'd1);
        cmp("A.restart.line_start", 32'(bus_a.line_start), 32'd1);
        cmp("A.restart.video_on", 32'(bus_a.video_on), 32'd1);
        step(1'b1);
        cmp("A.restart.pulse_end", 32'(bus_a.frame_start), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
